bitwise_logic_acc: RTL and testbench
====================================

# bitwise_logic_acc

Parametrised, registered successor to the combinational bitwise operators in the ALU datapath. It applies one of eight bitwise logic operations to two WIDTH-bit operands, either per beat (single mode) or folded across a multi-beat operand stream ending on `in_last` (accumulate mode). Results carry zero/all-ones flags and a beat count. Input and output both use a valid/ready handshake, so the block sits between the operand sequencer and the result register file.

## Interface
- `WIDTH`, 4: operand and result width in bits (≥1).
- `CNT_W`, 3: beat-counter width in bits; count saturates at 2^CNT_W−1.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset (sampled on `clk` rising edge).
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `op`  in  3  operation select; 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT x, 111 PASS x.
- `acc_mode`  in  1  0 = single, 1 = accumulate. Sampled only on a stream's first beat.
- `in_last`  in  1  final beat of an accumulate stream; ignored in single mode.
- `a`, `b`  in  WIDTH  operands.
- `out_valid`  out  1  result held and valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `result`  out  WIDTH  operation result.
- `zero`  out  1  `result` == 0.
- `ones`  out  1  `result` == all ones.
- `beats`  out  CNT_W  number of beats folded into `result`, saturating.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- Operation function f(x,y): AND x&y, OR x|y, XOR x^y, NAND ~(x&y), NOR ~(x|y), XNOR ~(x^y), NOT ~x, PASS x.
- States:
  - IDLE: no result held.
  - ACC: accumulating a stream.
  - HOLD: result valid.
- `in_ready` = (state != HOLD) || `out_ready`.
- `out_valid` = (state == HOLD).
- First beat (accepted in IDLE, or in HOLD with `out_ready`=1):
  - Latch `op` and `acc_mode`.
  - acc ← f(a,b); cnt ← 1.
  - If `acc_mode`=0, or `acc_mode`=1 with `in_last`=1: go to HOLD and publish acc.
  - Otherwise go to ACC.
- ACC beat:
  - acc ← f(acc, a) using the latched op. `b`, `op` and `acc_mode` are ignored.
  - cnt ← min(cnt+1, 2^CNT_W−1).
  - On `in_last`=1: go to HOLD and publish.
  - In ACC, `in_valid`=0 leaves state unchanged.
- HOLD:
  - `result`, `zero`, `ones` and `beats` stay stable until `out_ready`=1.
  - `out_ready`=1 with no accepted beat → IDLE. `out_valid` drops next cycle; `result` keeps its last value.
  - `out_ready`=1 with an accepted beat → treated as a first beat, as above.
- Flags are registered together with `result`. They are never combinational on inputs.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `out_valid`=0, `result`=0, `zero`=0, `ones`=0, `beats`=0, acc and cnt cleared. `in_ready`=1 from the first cycle after reset.
- Reset mid-operation (in ACC or HOLD) discards the partial stream and any pending result. No output appears.
- Single-mode latency: beat accepted at edge N → `out_valid`=1 with the result after edge N.
- With `out_ready` held high, throughput is one result per cycle.
- Accumulate mode, k beats: `out_valid` rises after the edge that accepts the `in_last` beat.
- Backpressure: `out_ready`=0 in HOLD forces `in_ready`=0. No beat is lost or overwritten.
- `beats` saturates at 2^CNT_W−1 (7 by default). acc keeps folding correctly past saturation.
- Combinational paths: only `out_ready` → `in_ready`.

## Test plan
- Reset then single OR: a=0101, b=0011, op=001, `out_ready`=1 → next cycle `result`=0111, `zero`=0, `ones`=0, `beats`=1.
- Single back-to-back with `out_ready`=1: NAND(1111,1111) then XNOR(1010,0101) on consecutive cycles → `result`=0000 with `zero`=1, then 0000 with `zero`=1. `out_valid` stays high both cycles.
- Accumulate OR over 3 beats:
  - (a,b)=(0001,0000), then a=0100, then a=1010 with `in_last`.
  - Response: `result`=1111, `ones`=1, `beats`=3, valid exactly one cycle after the last beat.
- Backpressure: hold `out_ready`=0 for 4 cycles after a result → `in_ready`=0, `result` stable. `out_ready`=1 → handshake completes, then IDLE.
- Saturation: 10-beat XOR accumulate of a=0001 with b=0000 → `result`=0000 (10 ones XORed), `beats`=7.
- Reset mid-stream: assert `rst_n`=0 after 2 of 4 accumulate beats → `out_valid`=0, `result`=0, `beats`=0. A following single AND(1100,1010) returns 1000.

Source files
------------

// File: rtl/bitwise_logic_acc_if.sv
// Operand/result bus for bitwise_logic_acc: an operand beat stream in, a result stream out.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the sender holds its payload stable until then.
interface bitwise_logic_acc_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc_mode;
    logic             in_last;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ones;
    logic [CNT_W-1:0] beats;

    modport master (
        output in_valid, op, acc_mode, in_last, a, b, out_ready,
        input  in_ready, out_valid, result, zero, ones, beats
    );

    modport slave (
        input  in_valid, op, acc_mode, in_last, a, b, out_ready,
        output in_ready, out_valid, result, zero, ones, beats
    );
endinterface

// File: rtl/bitwise_logic_acc.sv
// Registered bitwise logic unit: applies one of eight bitwise ops per beat, or folds
// a multi-beat operand stream into one result, with zero/all-ones flags and a beat count.
module bitwise_logic_acc #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    bitwise_logic_acc_if.slave bus,
    output logic [1:0]         state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ones_q;
    logic [CNT_W-1:0] beats_q;

    logic             in_ready_w;
    logic             accept;
    logic [WIDTH-1:0] first_val;
    logic [WIDTH-1:0] fold_val;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] sel,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (sel)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = x ^ y;
            3'b011:  r = ~(x & y);
            3'b100:  r = ~(x | y);
            3'b101:  r = ~(x ^ y);
            3'b110:  r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    // out_ready -> in_ready is the only combinational path through the block.
    assign in_ready_w = (state_q != HOLD) || bus.out_ready;
    assign accept     = bus.in_valid && in_ready_w;

    always_comb begin
        first_val = apply_op(bus.op, bus.a, bus.b);
        fold_val  = apply_op(op_q, acc_q, bus.a);
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'b000;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ones_q   <= 1'b0;
            beats_q  <= '0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        // Stream start: op is captured here and reused for every later fold.
                        op_q  <= bus.op;
                        acc_q <= first_val;
                        cnt_q <= CNT_ONE;
                        if (!bus.acc_mode || bus.in_last) begin
                            state_q  <= HOLD;
                            result_q <= first_val;
                            zero_q   <= (first_val == '0);
                            ones_q   <= (first_val == '1);
                            beats_q  <= CNT_ONE;
                        end else begin
                            state_q <= ACC;
                        end
                    end else if (state_q == HOLD && bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                ACC: begin
                    if (bus.in_valid) begin
                        acc_q <= fold_val;
                        cnt_q <= cnt_inc;
                        if (bus.in_last) begin
                            state_q  <= HOLD;
                            result_q <= fold_val;
                            zero_q   <= (fold_val == '0);
                            ones_q   <= (fold_val == '1);
                            beats_q  <= cnt_inc;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
    assign bus.beats     = beats_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_bitwise_logic_acc.sv
// Bench for bitwise_logic_acc: single-op vector table, accumulate, backpressure,
// saturation and mid-stream reset, with a result scoreboard on the output handshake.
module tb_bitwise_logic_acc;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  localparam int EW    = WIDTH + 2 + CNT_W;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;
  logic [EW-1:0] exp_q[$];
  vec_t       vecs[8];

  bitwise_logic_acc_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  bitwise_logic_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [EW-1:0] mk_exp(input logic [WIDTH-1:0] res, input logic [CNT_W-1:0] n);
    return {res, (res == 4'b0000), (res == 4'b1111), n};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: present one beat and wait (bounded) until it is accepted
  task automatic drive(input logic [2:0] o, input logic m, input logic l,
                       input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.acc_mode = m;
    bus.in_last  = l;
    bus.a        = x;
    bus.b        = y;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drive_timeout: got in_ready 0 expected 1");
    end
  endtask

  // scoreboard: compare each result as it is handed over
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", bus.result);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("sb_result", 32'(bus.result), 32'(e[EW-1 -: WIDTH]));
        check("sb_zero",   32'(bus.zero),   32'(e[CNT_W+1]));
        check("sb_ones",   32'(bus.ones),   32'(e[CNT_W]));
        check("sb_beats",  32'(bus.beats),  32'(e[CNT_W-1:0]));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.op = 3'b000; bus.acc_mode = 1'b0; bus.in_last = 1'b0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;

    vecs[0] = '{3'b011, 4'b1111, 4'b1111, 4'b0000};  // NAND
    vecs[1] = '{3'b101, 4'b1010, 4'b0101, 4'b0000};  // XNOR
    vecs[2] = '{3'b000, 4'b1100, 4'b1010, 4'b1000};  // AND
    vecs[3] = '{3'b010, 4'b0110, 4'b0011, 4'b0101};  // XOR
    vecs[4] = '{3'b100, 4'b0001, 4'b0010, 4'b1100};  // NOR
    vecs[5] = '{3'b110, 4'b0101, 4'b1111, 4'b1010};  // NOT
    vecs[6] = '{3'b111, 4'b1001, 4'b0110, 4'b1001};  // PASS
    vecs[7] = '{3'b001, 4'b1111, 4'b0000, 4'b1111};  // OR

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_result",    32'(bus.result),    0);
    check("rst_zero",      32'(bus.zero),      0);
    check("rst_ones",      32'(bus.ones),      0);
    check("rst_beats",     32'(bus.beats),     0);
    check("rst_in_ready",  32'(bus.in_ready),  1);
    check("rst_state",     32'(state_dbg),     0);

    // single OR, one-cycle latency
    bus.out_ready = 1'b1;
    exp_q.push_back(mk_exp(4'b0111, 3'd1));
    drive(3'b001, 1'b0, 1'b0, 4'b0101, 4'b0011);
    check("or_valid", 32'(bus.out_valid), 1);
    @(posedge clk); #1;
    check("or_idle", 32'(bus.out_valid), 0);

    // back-to-back single ops from the table
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk_exp(vecs[i].res, 3'd1));
      drive(vecs[i].op, 1'b0, (i % 2) == 1, vecs[i].a, vecs[i].b);
      check("tbl_valid", 32'(bus.out_valid), 1);
    end
    @(posedge clk); #1;
    check("tbl_idle", 32'(bus.out_valid), 0);

    // accumulate OR over 3 beats with a gap; later op/b must be ignored
    exp_q.push_back(mk_exp(4'b1111, 3'd3));
    drive(3'b001, 1'b1, 1'b0, 4'b0001, 4'b0000);
    check("acc_state1", 32'(state_dbg), 1);
    check("acc_nvalid1", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    check("acc_gap_state", 32'(state_dbg), 1);
    drive(3'b000, 1'b0, 1'b0, 4'b0100, 4'b1111);
    check("acc_nvalid2", 32'(bus.out_valid), 0);
    drive(3'b000, 1'b0, 1'b1, 4'b1010, 4'b1111);
    check("acc_valid", 32'(bus.out_valid), 1);
    @(posedge clk); #1;

    // backpressure with a second beat waiting
    bus.out_ready = 1'b0;
    exp_q.push_back(mk_exp(4'b1001, 3'd1));
    exp_q.push_back(mk_exp(4'b0011, 3'd1));
    drive(3'b010, 1'b0, 1'b0, 4'b1100, 4'b0101);
    bus.in_valid = 1'b1; bus.op = 3'b000; bus.acc_mode = 1'b0; bus.in_last = 1'b0;
    bus.a = 4'b1111; bus.b = 4'b0011;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready",  32'(bus.in_ready),  0);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_result",    32'(bus.result),    32'h9);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_second_valid", 32'(bus.out_valid), 1);
    @(posedge clk); #1;
    check("bp_idle_valid", 32'(bus.out_valid), 0);
    check("bp_idle_state", 32'(state_dbg), 0);

    // 10-beat XOR accumulate: count saturates, fold continues
    exp_q.push_back(mk_exp(4'b0000, 3'd7));
    for (int i = 0; i < 10; i++)
      drive(3'b010, i == 0, i == 9, 4'b0001, 4'b0000);
    check("sat_valid", 32'(bus.out_valid), 1);
    @(posedge clk); #1;

    // reset in the middle of a stream
    drive(3'b000, 1'b1, 1'b0, 4'b1111, 4'b1111);
    drive(3'b000, 1'b1, 1'b0, 4'b1110, 4'b0000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_result", 32'(bus.result),   0);
    check("mid_rst_zero",  32'(bus.zero),      0);
    check("mid_rst_beats", 32'(bus.beats),     0);
    check("mid_rst_state", 32'(state_dbg),     0);
    exp_q.push_back(mk_exp(4'b1000, 3'd1));
    drive(3'b000, 1'b0, 1'b0, 4'b1100, 4'b1010);
    check("post_rst_valid", 32'(bus.out_valid), 1);
    @(posedge clk); #1;

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
